alu_mul_seq: RTL
================

# alu_mul_seq

Sequential unsigned 32×32 multiplier that acts as the initiator on the ALU interface. It accepts operand pairs through a start/ready handshake and drives the combinational ALU's `op`/`in_r`/`in_rw` inputs one operation per cycle. It consumes the ALU's `out`/`is_zero` and computes the low 32 bits of the product by shift-and-add. It sits beside the ALU in the execute stage and shares the ALU's 4-bit opcode encoding.

## Interface

Parameters:
- `WIDTH`, 32: operand, product and ALU datapath width; only 32 is supported.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; accepted on a rising edge where `start && ready`.
- `in_a`  in  32  multiplicand; sampled on accept.
- `in_b`  in  32  multiplier; sampled on accept.
- `ready`  out  1  high in IDLE only.
- `done`  out  1  one-cycle pulse; result valid.
- `product`  out  32  low 32 bits of `in_a*in_b`; held until the next accept.
- `prod_zero`  out  1  `product == 0`; registered with `product`.
- `ovf`  out  1  true product exceeded 32 bits (see Configuration).
- `alu_op`  out  4  ALU opcode.
- `alu_in_r`  out  32  ALU first operand.
- `alu_in_rw`  out  32  ALU second operand.
- `alu_out`  in  32  ALU result, combinational in the same cycle.
- `alu_is_zero`  in  1  ALU zero flag, combinational in the same cycle.

## Operation

- Internal registers: `mcand`, `mplier`, `acc` (32 bits each), `lost` (1 bit), state.
- On accept: `mcand=in_a`, `mplier=in_b`, `acc=0`, `lost=0`, `ovf=0`, go to CHECK.
- ALU opcodes used: ADD 0000, shift-left-by-`in_rw` 0010, shift-right-by-`in_rw` 0011, pass-second-operand 0101.
- States and transitions:
  - IDLE: `alu_op=0000`, `alu_in_r=0`, `alu_in_rw=0`.
  - CHECK: op 0101 with `in_rw=mplier`. If `alu_is_zero`, go to DONE. Otherwise go to ADD if `mplier[0]`, else SHL.
  - ADD: op 0000 with `in_r=acc`, `in_rw=mcand`. Set `acc=alu_out`. Go to SHL.
  - SHL: op 0010 with `in_r=mcand`, `in_rw=1`. Set `mcand=alu_out` and `lost|=mcand[31]`. Go to SHR.
  - SHR: op 0011 with `in_r=mplier`, `in_rw=1`. Set `mplier=alu_out`. If `alu_is_zero`, go to DONE. Otherwise go to ADD if `alu_out[0]`, else SHL.
  - DONE: load `product=acc` and `prod_zero=(acc==0)`, pulse `done`, return to IDLE.
- Arithmetic is modulo 2^32 and unsigned; no sign handling.
- `start` while not `ready` is ignored; it is neither queued nor allowed to corrupt the operation in flight.
- `in_a`/`in_b` are don't-care after accept.

## Timing

- Reset values: `ready=1`, `done=0`, `product=0`, `prod_zero=1`, `ovf=0`, `alu_op=0`, `alu_in_r=0`, `alu_in_rw=0`, state IDLE.
- Reset asserted mid-operation aborts immediately to the reset values; no `done` is produced.
- Latency from the accept edge to `done` high, in cycles: 2 + Σ over processed multiplier bits of (2 + bit). Processing stops after the highest set bit of `in_b`.
  - `in_b=0`: 2.
  - `in_b=5`: 10.
  - `in_b=0xFFFFFFFF`: 98.
- `ready` is low from the cycle after accept until the cycle after `done`. Back-to-back accept is possible on the edge that ends DONE+1, so throughput is latency+1.
- ALU outputs are purely combinational from registered state; there is no ALU result register.

## Configuration

- `ALU_MUL_OVF_EN` defined: `ovf` is computed and is sticky within an operation. It sets in ADD when `alu_out < acc` (carry out). It sets in SHR when `lost` is set and `!alu_is_zero` (a dropped multiplicand bit would still be needed). It is loaded to the output at DONE.
- Not defined: `ovf` is constant 0, and the `lost` register and carry compare are not instantiated. All other behaviour and latency are identical.

## Test plan

- Reset, then `in_a=3`, `in_b=5`, `start` → `done` in cycle 10 after accept, `product=15`, `prod_zero=0`, `ovf=0`.
- `in_a=2536`, `in_b=0` → `done` at cycle 2, `product=0`, `prod_zero=1`, ALU sees op 0101 in CHECK.
- `in_a=2536`, `in_b=113` → `product=286568`. A trace of `alu_op` shows the sequence ADD/SHL/SHR per set bit and SHL/SHR per clear bit.
- `in_a=0x10000`, `in_b=0x10000` → `product=0`, `prod_zero=1`, and `ovf=1` with `ALU_MUL_OVF_EN` (0 without it).
- `in_a=in_b=0xFFFFFFFF` → `done` at cycle 98, `product=1`, `ovf=1` with the macro defined.
- Start `7×9`, pulse `start` again at cycle 3 with other operands, then assert `resetn=0` at cycle 5 of a second op → the first result is 63 and unaffected by the extra `start`. During the reset, outputs go to reset values immediately with no `done`.

Source files
------------

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - sequential shift-and-add 32x32 multiplier driving the combinational ALU
// Optional overflow detection is enabled by defining ALU_MUL_OVF_EN.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             prod_zero,
  output logic             ovf,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_in_r,
  output logic [WIDTH-1:0] alu_in_rw,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_is_zero
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SHL  = 4'b0010;
  localparam logic [3:0] OP_SHR  = 4'b0011;
  localparam logic [3:0] OP_PASS = 4'b0101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ADD,
    S_SHL,
    S_SHR,
    S_DONE
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;

  assign ready = (state == S_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      product   <= '0;
      prod_zero <= 1'b1;
      done      <= 1'b0;
    end else begin
      state <= state_n;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand  <= in_a;
            mplier <= in_b;
            acc    <= '0;
          end
        end
        S_ADD:  acc    <= alu_out;
        S_SHL:  mcand  <= alu_out;
        S_SHR:  mplier <= alu_out;
        S_DONE: begin
          product   <= acc;
          prod_zero <= (acc == '0);
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_MUL_OVF_EN
  // lost: a multiplicand bit has been shifted out; it only matters if multiplier bits remain
  logic lost;
  logic ovf_acc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lost    <= 1'b0;
      ovf_acc <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            lost    <= 1'b0;
            ovf_acc <= 1'b0;
            ovf     <= 1'b0;
          end
        end
        S_ADD: begin
          if (alu_out < acc) ovf_acc <= 1'b1;
        end
        S_SHL: lost <= lost | mcand[WIDTH-1];
        S_SHR: begin
          if (lost && !alu_is_zero) ovf_acc <= 1'b1;
        end
        S_DONE: ovf <= ovf_acc;
        default: ;
      endcase
    end
  end
`else
  assign ovf = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    alu_op    = OP_ADD;
    alu_in_r  = '0;
    alu_in_rw = '0;
    case (state)
      S_IDLE: begin
        if (start) state_n = S_CHECK;
      end
      S_CHECK: begin
        alu_op    = OP_PASS;
        alu_in_rw = mplier;
        if (alu_is_zero)    state_n = S_DONE;
        else if (mplier[0]) state_n = S_ADD;
        else                state_n = S_SHL;
      end
      S_ADD: begin
        alu_op    = OP_ADD;
        alu_in_r  = acc;
        alu_in_rw = mcand;
        state_n   = S_SHL;
      end
      S_SHL: begin
        alu_op    = OP_SHL;
        alu_in_r  = mcand;
        alu_in_rw = WIDTH'(1);
        state_n   = S_SHR;
      end
      S_SHR: begin
        alu_op    = OP_SHR;
        alu_in_r  = mplier;
        alu_in_rw = WIDTH'(1);
        if (alu_is_zero)     state_n = S_DONE;
        else if (alu_out[0]) state_n = S_ADD;
        else                 state_n = S_SHL;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

endmodule
